regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
- REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries.
- REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = entry 0 hardwired to zero; 0 = entry 0 is an ordinary register.
- REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
- REQ-006 SHALL have port rs1, rs2  input  ADDR_W  read addresses.
- REQ-007 SHALL have port rs1_data, rs2_data  output  DATA_W  combinational read data.
- REQ-008 SHALL have port we0, we1  input  1  write enables, ports 0 and 1.
- REQ-009 SHALL have port wa0, wa1  input  ADDR_W  write addresses.
- REQ-010 SHALL have port wd0, wd1  input  DATA_W  write data.
- REQ-011 SHALL have port alloc_en  input  1  mark alloc_rd pending (producer issued).
- REQ-012 SHALL have port alloc_rd  input  ADDR_W  register to mark pending.
- REQ-013 SHALL have port rs1_busy, rs2_busy  output  1  pending bit of rs1 and rs2.
- REQ-014 SHALL have port clr_req  input  1  one-cycle request to start the clear sweep.
- REQ-015 SHALL have port clr_busy  output  1  high while the clear sweep runs.

Function
- REQ-016 SHALL write wdN to entry waN on a clock edge with weN=1, in state IDLE only.
- REQ-017 SHALL drop a write to entry 0 when ZERO_REG=1.
- REQ-018 SHALL give port 1 priority when we0=we1=1 and wa0==wa1: entry takes wd1.
- REQ-019 SHALL return 0 on rsX_data for rsX==0 when ZERO_REG=1, regardless of writes.
- REQ-020 SHALL bypass each read port: if rsX matches an active, non-dropped write this cycle, rsX_data = that write data (port 1 over port 0), otherwise the stored value.
- REQ-021 SHALL keep a DEPTH-bit pending vector: alloc_en sets bit alloc_rd; a write on either port clears bit waN.
- REQ-022 SHALL resolve alloc and write to the same entry in one cycle as pending=1 (the new producer wins).
- REQ-023 SHALL never set pending bit 0 when ZERO_REG=1.
- REQ-024 SHALL drive rsX_busy from the registered pending bit, with no same-cycle bypass.
- REQ-025 SHALL have controller states IDLE and CLEAR.
- REQ-026 SHALL go IDLE->CLEAR on clr_req=1, with sweep counter = 0.
- REQ-027 SHALL, in CLEAR, zero entry[counter] and pending[counter] each cycle, then increment counter.
- REQ-028 SHALL return to IDLE after zeroing entry DEPTH-1, for exactly DEPTH cycles in CLEAR.
- REQ-029 SHALL, in CLEAR, drop all writes, alloc_en and clr_req.
- REQ-030 SHALL, in CLEAR, disable bypass; reads return stored (partially cleared) values.
- REQ-031 SHALL drive clr_busy = 1 exactly while state == CLEAR.
- REQ-032 SHALL give sweep counter width ADDR_W, with wrap DEPTH-1 -> 0 coinciding with the return to IDLE.

Reset
- REQ-033 SHALL, on rst=1 at a clock edge, zero all entries and all pending bits, force state IDLE, and zero the counter.
- REQ-034 SHALL give rst priority over writes, alloc and clr_req in the same cycle.
- REQ-035 SHALL, on rst during CLEAR, abort the sweep; clr_busy=0 the next cycle.
- REQ-036 SHALL hold these output values after reset:
  - rs1_data and rs2_data = 0 for any address with no write active;
  - rs1_busy = rs2_busy = 0;
  - clr_busy = 0.

Verification
- REQ-037 SHALL cover: we0=1, wa0=3, wd0=0x1234 with rs1=3 in the same cycle -> rs1_data=0x1234 (bypass); next cycle with no write, rs1=3 -> 0x1234.
- REQ-038 SHALL cover: we0=we1=1, wa0=wa1=5, wd0=0xAAAA, wd1=0x5555 -> rs2=5 reads 0x5555 during and after.
- REQ-039 SHALL cover: ZERO_REG=1, write 0xFFFF to 0 and alloc_en with alloc_rd=0 -> rs1=0 reads 0, rs1_busy=0.
- REQ-040 SHALL cover: alloc 7 -> rs1_busy=1 next cycle; write 7 -> busy=0 next cycle; alloc 7 and write 7 together -> busy stays 1.
- REQ-041 SHALL cover: fill all 16 entries, pulse clr_req -> clr_busy high 16 cycles.
  - A write to 2 during the sweep is dropped.
  - Afterwards all reads = 0 and all busy = 0.
- REQ-042 SHALL cover: rst asserted on sweep cycle 4 -> next cycle clr_busy=0, all reads 0, and a new write succeeds.

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Two-read / two-write register file with a per-entry pending ("scoreboard")
// bit and a sequential clear sweep that zeroes one entry per cycle.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; the file holds 2**ADDR_W entries
//   ZERO_REG  1: entry 0 reads as zero, ignores writes, never goes pending
//             0: entry 0 is an ordinary register
//
// Ports
//   clk                 sole clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   rs1, rs2            read addresses
//   rs1_data, rs2_data  combinational read data, with same-cycle write bypass
//   rs1_busy, rs2_busy  registered pending bits of rs1 / rs2 (no bypass)
//   we0/wa0/wd0         write port 0
//   we1/wa1/wd1         write port 1 (wins over port 0 on an address clash)
//   alloc_en/alloc_rd   mark alloc_rd pending (a producer has been issued)
//   clr_req             one-cycle request to start the clear sweep
//   clr_busy            high while the clear sweep runs
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
    localparam logic              HARD_ZERO  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;

    logic in_idle;
    logic wr0;
    logic wr1;
    logic alloc_ok;
    logic bypass_ok;

    // Qualified request strobes. Everything that modifies the file is only
    // honoured in IDLE; writes and allocations aimed at a hardwired entry 0
    // are discarded here so the datapath below never has to special-case it.
    assign in_idle   = (state == IDLE);
    assign wr0       = we0 && in_idle && !(HARD_ZERO && (wa0 == '0));
    assign wr1       = we1 && in_idle && !(HARD_ZERO && (wa1 == '0));
    assign alloc_ok  = alloc_en && in_idle && !(HARD_ZERO && (alloc_rd == '0));

    // Bypass only forwards writes that will really land at the coming edge,
    // so it is suppressed during reset as well as during the sweep.
    assign bypass_ok = in_idle && !rst;

    assign clr_busy  = (state == CLEAR);
    assign rs1_busy  = pending[rs1];
    assign rs2_busy  = pending[rs2];

    // Controller next-state logic. The sweep counter is loaded with zero on
    // entry to CLEAR and walks every entry once; its natural wrap from the
    // last entry back to zero lines up with the return to IDLE. A clr_req
    // seen while already sweeping is ignored.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == LAST_ENTRY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Controller state register. Reset aborts a sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Storage array. Port 1's assignment comes after port 0's so that when
    // both target the same entry the later non-blocking update (port 1)
    // is the one that sticks. During the sweep only the entry under the
    // counter changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else begin
            if (wr0) begin
                regs[wa0] <= wd0;
            end
            if (wr1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Pending vector update. A completing write clears its entry's bit,
    // then a same-cycle allocation sets it again: the newly issued producer
    // is the one still outstanding, so pending must stay set.
    always_comb begin
        pending_next = pending;
        if (state == CLEAR) begin
            pending_next[cnt] = 1'b0;
        end else begin
            if (wr0) begin
                pending_next[wa0] = 1'b0;
            end
            if (wr1) begin
                pending_next[wa1] = 1'b0;
            end
            if (alloc_ok) begin
                pending_next[alloc_rd] = 1'b1;
            end
        end
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Read port 1: stored value, overridden by a same-cycle write (port 1
    // ahead of port 0), and forced to zero for a hardwired entry 0.
    always_comb begin
        rs1_data = regs[rs1];
        if (bypass_ok) begin
            if (wr1 && (rs1 == wa1)) begin
                rs1_data = wd1;
            end else if (wr0 && (rs1 == wa0)) begin
                rs1_data = wd0;
            end
        end
        if (HARD_ZERO && (rs1 == '0)) begin
            rs1_data = '0;
        end
    end

    // Read port 2: identical structure to read port 1.
    always_comb begin
        rs2_data = regs[rs2];
        if (bypass_ok) begin
            if (wr1 && (rs2 == wa1)) begin
                rs2_data = wd1;
            end else if (wr0 && (rs2 == wa0)) begin
                rs2_data = wd0;
            end
        end
        if (HARD_ZERO && (rs2 == '0)) begin
            rs2_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//
// Self-checking bench for regfile_sb with default parameters
// (DATA_W=16, ADDR_W=4, ZERO_REG=1). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well before the next rising edge.
// A table of single-cycle vectors covers bypass, port priority, entry 0 and
// the pending bits; hand-written sequences cover reset priority, the clear
// sweep and reset during a sweep.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        we0;
    logic        we1;
    logic [3:0]  wa0;
    logic [3:0]  wa1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    logic        alloc_en;
    logic [3:0]  alloc_rd;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        clr_req;
    logic        clr_busy;

    int checks;
    int errors;

    typedef struct packed {
        logic        we0;
        logic [3:0]  wa0;
        logic [15:0] wd0;
        logic        we1;
        logic [3:0]  wa1;
        logic [15:0] wd1;
        logic        alloc_en;
        logic [3:0]  alloc_rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic        expb1;
        logic        expb2;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    regfile_sb #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .ZERO_REG(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .we0     (we0),
        .we1     (we1),
        .wa0     (wa0),
        .wa1     (wa1),
        .wd0     (wd0),
        .wd1     (wd1),
        .alloc_en(alloc_en),
        .alloc_rd(alloc_rd),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .clr_req (clr_req),
        .clr_busy(clr_busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value written to entry i when the whole file is filled before a sweep.
    function automatic logic [15:0] fillVal(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    // One comparison: bumps the check count and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Return every stimulus input to its quiet value.
    task automatic quietInputs();
        we0      = 1'b0;
        we1      = 1'b0;
        wa0      = 4'd0;
        wa1      = 4'd0;
        wd0      = 16'h0000;
        wd1      = 16'h0000;
        alloc_en = 1'b0;
        alloc_rd = 4'd0;
        clr_req  = 1'b0;
    endtask

    // Drive one table vector onto the DUT inputs.
    task automatic applyStimulus(input vec_t v);
        we0      = v.we0;
        wa0      = v.wa0;
        wd0      = v.wd0;
        we1      = v.we1;
        wa1      = v.wa1;
        wd1      = v.wd1;
        alloc_en = v.alloc_en;
        alloc_rd = v.alloc_rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        clr_req  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rs1    = 4'd0;
        rs2    = 4'd0;
        quietInputs();

        // Fields: we0 wa0 wd0 | we1 wa1 wd1 | alloc_en alloc_rd | rs1 rs2 |
        //         exp rs1_data, exp rs2_data, exp rs1_busy, exp rs2_busy
        vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd3, 4'd5,  16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd3, 4'd0,  16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd3, 4'd3,  16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5,  16'h5555, 1'b0, 4'd0, 4'd5, 4'd5,  16'h5555, 16'h5555, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd5, 4'd5,  16'h5555, 16'h5555, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd0, 4'd0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 4'd7, 4'd3,  16'h0000, 16'h1234, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd7, 4'd7,  16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7,  16'h0777, 1'b0, 4'd0, 4'd7, 4'd7,  16'h0777, 16'h0777, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd7, 4'd3,  16'h0777, 16'h1234, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'd7, 16'h0ABC, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 4'd7, 4'd7,  16'h0ABC, 16'h0ABC, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd7, 4'd7,  16'h0ABC, 16'h0ABC, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 4'd7, 16'h1111, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd7, 4'd5,  16'h1111, 16'h5555, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd7, 4'd3,  16'h1111, 16'h1234, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 4'd9, 16'h0909, 1'b1, 4'd10, 16'h0A0A, 1'b0, 4'd0, 4'd9, 4'd10, 16'h0909, 16'h0A0A, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd9, 4'd10, 16'h0909, 16'h0A0A, 1'b0, 1'b0};

        // Reset with a write, an allocation and a clear request all present:
        // reset must win over every one of them.
        @(negedge clk);
        we0      = 1'b1;
        wa0      = 4'd1;
        wd0      = 16'h7777;
        alloc_en = 1'b1;
        alloc_rd = 4'd1;
        clr_req  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        quietInputs();
        rs1 = 4'd1;
        rs2 = 4'd2;
        #1;
        checkOutput("reset_rs1_data", 32'(rs1_data), 32'h0);
        checkOutput("reset_rs2_data", 32'(rs2_data), 32'h0);
        checkOutput("reset_rs1_busy", 32'(rs1_busy), 32'h0);
        checkOutput("reset_rs2_busy", 32'(rs2_busy), 32'h0);
        checkOutput("reset_clr_busy", 32'(clr_busy), 32'h0);

        // Table-driven single-cycle vectors.
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            applyStimulus(vecs[v]);
            #1;
            checkOutput($sformatf("vec%0d_rs1_data", v), 32'(rs1_data), 32'(vecs[v].exp1));
            checkOutput($sformatf("vec%0d_rs2_data", v), 32'(rs2_data), 32'(vecs[v].exp2));
            checkOutput($sformatf("vec%0d_rs1_busy", v), 32'(rs1_busy), 32'(vecs[v].expb1));
            checkOutput($sformatf("vec%0d_rs2_busy", v), 32'(rs2_busy), 32'(vecs[v].expb2));
        end

        // Fill every entry, mark two pending, then run a full clear sweep.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            quietInputs();
            we0 = 1'b1;
            wa0 = 4'(i);
            wd0 = fillVal(i);
        end
        @(negedge clk);
        quietInputs();
        alloc_en = 1'b1;
        alloc_rd = 4'd4;
        @(negedge clk);
        alloc_rd = 4'd12;
        @(negedge clk);
        quietInputs();
        rs1     = 4'd4;
        rs2     = 4'd12;
        clr_req = 1'b1;
        #1;
        checkOutput("fill_rs1_data", 32'(rs1_data), 32'(fillVal(4)));
        checkOutput("fill_rs1_busy", 32'(rs1_busy), 32'h1);
        checkOutput("fill_rs2_busy", 32'(rs2_busy), 32'h1);
        checkOutput("clr_req_cycle_clr_busy", 32'(clr_busy), 32'h0);

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            quietInputs();
            if (k == 4) begin
                rs1 = 4'd4;
                rs2 = 4'd12;
            end
            if (k == 5) begin
                we0 = 1'b1;
                wa0 = 4'd2;
                wd0 = 16'hBEEF;
                rs1 = 4'd2;
                rs2 = 4'd9;
            end
            if (k == 6) begin
                alloc_en = 1'b1;
                alloc_rd = 4'd3;
            end
            if (k == 10) begin
                clr_req = 1'b1;
            end
            #1;
            checkOutput($sformatf("sweep%0d_clr_busy", k), 32'(clr_busy), 32'h1);
            if (k == 4) begin
                checkOutput("sweep4_rs1_data", 32'(rs1_data), 32'(fillVal(4)));
                checkOutput("sweep4_rs1_busy", 32'(rs1_busy), 32'h1);
            end
            if (k == 5) begin
                checkOutput("sweep5_rs1_no_bypass", 32'(rs1_data), 32'h0);
                checkOutput("sweep5_rs2_unswept", 32'(rs2_data), 32'(fillVal(9)));
            end
        end
        @(negedge clk);
        quietInputs();
        #1;
        checkOutput("sweep_done_clr_busy", 32'(clr_busy), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rs1 = 4'(i);
            rs2 = 4'(15 - i);
            #1;
            checkOutput($sformatf("post_sweep_rs1_data_%0d", i), 32'(rs1_data), 32'h0);
            checkOutput($sformatf("post_sweep_rs1_busy_%0d", i), 32'(rs1_busy), 32'h0);
            checkOutput($sformatf("post_sweep_rs2_data_%0d", 15 - i), 32'(rs2_data), 32'h0);
            checkOutput($sformatf("post_sweep_rs2_busy_%0d", 15 - i), 32'(rs2_busy), 32'h0);
        end

        // Reset on sweep cycle 4 aborts the sweep and zeroes unswept entries.
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            quietInputs();
            we0 = 1'b1;
            wa0 = 4'(i);
            wd0 = 16'(i) * 16'h1111;
        end
        @(negedge clk);
        quietInputs();
        alloc_en = 1'b1;
        alloc_rd = 4'd6;
        @(negedge clk);
        quietInputs();
        clr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            quietInputs();
        end
        rs1 = 4'd5;
        rs2 = 4'd6;
        #1;
        checkOutput("abort_cycle3_clr_busy", 32'(clr_busy), 32'h1);
        checkOutput("abort_cycle3_rs2_busy", 32'(rs2_busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_clr_busy", 32'(clr_busy), 32'h0);
        checkOutput("abort_rs1_data", 32'(rs1_data), 32'h0);
        checkOutput("abort_rs2_data", 32'(rs2_data), 32'h0);
        checkOutput("abort_rs2_busy", 32'(rs2_busy), 32'h0);
        @(negedge clk);
        we0 = 1'b1;
        wa0 = 4'd6;
        wd0 = 16'hC0DE;
        @(negedge clk);
        quietInputs();
        rs1 = 4'd6;
        #1;
        checkOutput("after_abort_write", 32'(rs1_data), 32'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
